dcache_wt: RTL
==============

Name: dcache_wt

Overview:
Direct-mapped, write-through, no-write-allocate data cache that responds to the memory stage's Mcache interface. It returns load words, absorbs stores and generates MCACHE_STALL_SM. Misses and all stores go to a single-outstanding word-wide RAM bus. It sits between the MEM stage and the data RAM / bus fabric.

Parameters:
LINES, 64, number of cache lines (power of 2, >=2)
WORDS_PER_LINE, 4, 32-bit words per line (power of 2, >=2)

Ports:
clk  in  1  system clock
reset_n  in  1  reset; one clock; reset is asynchronous and active-low
MCACHE_ADR_SM  in  32  byte address from MEM stage
MCACHE_DATA_SM  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
MCACHE_ADR_VALID_SM  in  1  request valid
MCACHE_LOAD_SM  in  1  load request
MCACHE_STORE_SM  in  1  store request
byt_sel  in  4  byte lanes; 0000 = misaligned
MCACHE_RESULT_SM  out  32  full aligned load word (MEM stage extracts lanes)
MCACHE_STALL_SM  out  1  request not complete this cycle; core holds all inputs stable
RAM_ADR_SD  out  32  word-aligned bus address ([1:0]=00)
RAM_DATA_SD  out  32  bus write data, lane-aligned
RAM_BE_SD  out  4  bus byte enables
RAM_REQ_SD  out  1  bus request
RAM_WE_SD  out  1  1=write, 0=read
RAM_ACK_SX  in  1  one-cycle completion of current transfer
RAM_RDATA_SX  in  32  read data, valid with RAM_ACK_SX

Behaviour:
- Address split: offset [1:0]; word = next log2(WORDS_PER_LINE) bits; index = next log2(LINES) bits; tag = remaining upper bits.
- Storage: data array, tag array, valid bit per line.
- hit = valid[index] && tag match.
- Reset: all valid bits 0, FSM IDLE, counter 0, all outputs 0.
- Reset asserted mid-refill or mid-write abandons the transfer; a partially refilled line stays invalid.
- FSM states: IDLE, REFILL, WRITE.
- Request ignored (stall 0, result 0, no bus activity) when: ADR_VALID=0, byt_sel=0000, or neither LOAD nor STORE is set.
- LOAD and STORE both high: treated as a store.
- IDLE, load hit: RESULT = cached word, stall 0, same cycle (combinational).
- IDLE, load miss: stall 1, result 0. Next state REFILL, counter = 0.
- REFILL: REQ=1, WE=0, BE=1111, ADR = {tag,index,counter,00}. Words are fetched 0..WORDS_PER_LINE-1 in order, one per ACK.
  - Each ACK writes RDATA into data[index][counter] and increments the counter. ADR updates the cycle after ACK; REQ may stay high.
  - ACK on the last word: write the tag, set valid, go to IDLE.
  - The held load then hits in IDLE and stalls 0.
  - Load-miss latency = 1 + N transfers + 1 cycles.
  - Stall is 1 throughout REFILL.
- IDLE, store: stall 1, next state WRITE.
- WRITE: REQ=1, WE=1, BE=byt_sel, ADR = {addr[31:2],00}.
  - DATA is lane-shifted: byte replicated or shifted to the lane in byt_sel; half to [15:0] or [31:16]; word unchanged.
  - On ACK: stall=0 in the same cycle (combinational from ACK), so the core pops. If hit, merge the enabled bytes into the cached word. No allocate on miss. Next state IDLE.
- Stall in WRITE = !RAM_ACK_SX.
- ACK outside REFILL/WRITE is ignored.
- REQ, ADR, DATA, BE and WE are held stable until ACK.
- Only one bus transfer is outstanding at a time.
- Index aliasing: a refill overwrites the line unconditionally. Write-through means there is never dirty data.

Test Plan:
- Reset, then load 0x00000100, byt_sel 1111: bus reads 0x100, 0x104, 0x108, 0x10C (ACK each after 2 cycles). Stall stays 1 until the cycle after the 4th ACK, then RESULT = word from 0x100 with stall 0.
- Load 0x00000108 after the refill above: hit, stall 0 the same cycle, RESULT = the RAM word at 0x108, no REQ.
- Store byte 0xAB to 0x00000102 (byt_sel 0100) on a cached line: RAM_BE=0100, RAM_DATA[23:16]=AB, stall drops with ACK. A following load 0x100 hits with bits [23:16]=AB.
- Store word to an uncached address 0x00002000: one bus write, no refill. A following load 0x2000 misses and refills.
- Load from an address aliasing index 0x10 with a different tag: the line is refilled, and the old tag then misses.
- Assert reset_n=0 after 2 of 4 refill ACKs: REQ=0 and stall=0 immediately. After release, the same load misses again and performs a full 4-word refill.

Source files
------------

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Loads hit combinationally; misses refill a whole line over a single-outstanding
// word-wide bus. Every store is written through to the bus and merged into the
// cached word only when the line is already present.
module dcache_wt #(
  parameter int unsigned LINES          = 64,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] MCACHE_ADR_SM,
  input  logic [31:0] MCACHE_DATA_SM,
  input  logic        MCACHE_ADR_VALID_SM,
  input  logic        MCACHE_LOAD_SM,
  input  logic        MCACHE_STORE_SM,
  input  logic [3:0]  byt_sel,
  output logic [31:0] MCACHE_RESULT_SM,
  output logic        MCACHE_STALL_SM,
  output logic [31:0] RAM_ADR_SD,
  output logic [31:0] RAM_DATA_SD,
  output logic [3:0]  RAM_BE_SD,
  output logic        RAM_REQ_SD,
  output logic        RAM_WE_SD,
  input  logic        RAM_ACK_SX,
  input  logic [31:0] RAM_RDATA_SX
);

  localparam int unsigned WB    = $clog2(WORDS_PER_LINE);
  localparam int unsigned IB    = $clog2(LINES);
  localparam int unsigned TAGB  = 30 - WB - IB;
  localparam int unsigned DEPTH = LINES * WORDS_PER_LINE;
  localparam logic [WB-1:0] LAST_WORD = '1;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t         state_q, state_d;
  logic [WB-1:0]  cnt_q, cnt_d;

  logic [31:0]     data_mem [DEPTH];
  logic [TAGB-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid_q;

  logic [WB-1:0]   word_sel;
  logic [IB-1:0]   index;
  logic [TAGB-1:0] tag;
  logic [31:0]     lane_data;
  logic            hit;
  logic            req_ok;
  logic            start_refill;
  logic            refill_wr;
  logic            line_done;
  logic            store_merge;
  logic            unused_ok;

  assign word_sel  = MCACHE_ADR_SM[2 +: WB];
  assign index     = MCACHE_ADR_SM[2 + WB +: IB];
  assign tag       = MCACHE_ADR_SM[31 -: TAGB];
  assign unused_ok = ^MCACHE_ADR_SM[1:0];

  assign hit    = valid_q[index] && (tag_mem[index] == tag);
  assign req_ok = MCACHE_ADR_VALID_SM && (byt_sel != 4'b0000) &&
                  (MCACHE_LOAD_SM || MCACHE_STORE_SM);

  // Place right-aligned store data onto the lanes selected by byt_sel.
  // Bytes and halves are replicated so every candidate lane carries them.
  always_comb begin
    lane_data = MCACHE_DATA_SM;
    unique case (byt_sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: lane_data = {4{MCACHE_DATA_SM[7:0]}};
      4'b0011, 4'b1100:                   lane_data = {2{MCACHE_DATA_SM[15:0]}};
      default:                            lane_data = MCACHE_DATA_SM;
    endcase
  end

  // Next-state, core handshake and bus drive. Everything is gated by reset_n
  // so an asserted reset silences the bus and the stall immediately.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    MCACHE_RESULT_SM = '0;
    MCACHE_STALL_SM  = 1'b0;
    RAM_ADR_SD       = '0;
    RAM_DATA_SD      = '0;
    RAM_BE_SD        = '0;
    RAM_REQ_SD       = 1'b0;
    RAM_WE_SD        = 1'b0;
    start_refill     = 1'b0;
    refill_wr        = 1'b0;
    line_done        = 1'b0;
    store_merge      = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        IDLE: begin
          if (req_ok) begin
            if (MCACHE_STORE_SM) begin
              MCACHE_STALL_SM = 1'b1;
              state_d         = WRITE;
            end else if (hit) begin
              MCACHE_RESULT_SM = data_mem[{index, word_sel}];
            end else begin
              MCACHE_STALL_SM = 1'b1;
              state_d         = REFILL;
              cnt_d           = '0;
              start_refill    = 1'b1;
            end
          end
        end
        REFILL: begin
          MCACHE_STALL_SM = 1'b1;
          RAM_REQ_SD      = 1'b1;
          RAM_BE_SD       = 4'b1111;
          RAM_ADR_SD      = {tag, index, cnt_q, 2'b00};
          if (RAM_ACK_SX) begin
            refill_wr = 1'b1;
            cnt_d     = cnt_q + WB'(1);
            if (cnt_q == LAST_WORD) begin
              line_done = 1'b1;
              state_d   = IDLE;
            end
          end
        end
        WRITE: begin
          MCACHE_STALL_SM = !RAM_ACK_SX;
          RAM_REQ_SD      = 1'b1;
          RAM_WE_SD       = 1'b1;
          RAM_BE_SD       = byt_sel;
          RAM_ADR_SD      = {MCACHE_ADR_SM[31:2], 2'b00};
          RAM_DATA_SD     = lane_data;
          if (RAM_ACK_SX) begin
            store_merge = hit;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and refill word counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Line valid bits: cleared when a refill starts so a partial line never hits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (start_refill) begin
      valid_q[index] <= 1'b0;
    end else if (line_done) begin
      valid_q[index] <= 1'b1;
    end
  end

  // Tag array written once the last refill word lands.
  always_ff @(posedge clk) begin
    if (line_done) begin
      tag_mem[index] <= tag;
    end
  end

  // Data array: refill words, and byte-merged store data on a write hit.
  always_ff @(posedge clk) begin
    if (refill_wr) begin
      data_mem[{index, cnt_q}] <= RAM_RDATA_SX;
    end else if (store_merge) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byt_sel[b]) begin
          data_mem[{index, word_sel}][8*b +: 8] <= lane_data[8*b +: 8];
        end
      end
    end
  end

endmodule
